// File: rtl/uart_wave_cmd_rx.sv
// UART command front-end for the wave generator: 16x-oversampled receiver plus command decoder.
// Define UART_PARITY_EN to receive 8E1 frames (even parity checked) instead of 8N1.
module uart_wave_cmd_rx #(
  parameter int                CLK_HZ     = 25_000_000,
  parameter int                BAUD       = 9600,
  parameter int                FREQ_W     = 16,
  parameter logic [FREQ_W-1:0] FREQ_RESET = 16'h0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [2:0]        wave_sel,
  output logic              noise_en,
  output logic [FREQ_W-1:0] freq_word,
  output logic              cmd_valid,
  output logic              cmd_err
);

  localparam int DIV   = CLK_HZ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  typedef enum logic {DEC_CMD, DEC_HEX} dec_state_t;

  rx_state_t  rx_state_reg, rx_state_next;
  dec_state_t dec_state_reg, dec_state_next;

  logic             sync1_reg, rx_s;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [3:0]       tick_cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       data_reg;
  logic             vote0_reg, vote1_reg;
  logic             need_idle_reg;
  logic             byte_vld_reg, rx_err_reg;
  logic             tick, bit_end, mid_tick, maj, par_bad;

  logic [2:0]        wave_reg, wave_next;
  logic              noise_reg, noise_next;
  logic [FREQ_W-1:0] freq_reg, freq_next;
  logic [FREQ_W-1:0] shadow_reg, shadow_next;
  logic              has_digit_reg, has_digit_next;
  logic              valid_reg, valid_next;
  logic              err_reg, err_next;
  logic [4:0]        hex;

  function automatic logic [4:0] hex_val(input logic [7:0] c);
    hex_val = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)      hex_val = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) hex_val = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) hex_val = {1'b1, 4'(c - 8'h57)};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync1_reg <= rx;
      rx_s      <= sync1_reg;
    end
  end

  assign tick     = (div_cnt_reg == DIV_W'(DIV - 1));
  assign bit_end  = tick && (tick_cnt_reg == 4'd15);
  assign mid_tick = tick && (tick_cnt_reg == 4'd7);
  assign maj      = (vote0_reg & vote1_reg) | (vote0_reg & rx_s) | (vote1_reg & rx_s);

`ifdef UART_PARITY_EN
  logic par_bit_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      par_bit_reg <= 1'b0;
    else if (rx_state_reg == RX_PAR && tick && tick_cnt_reg == 4'd8)
      par_bit_reg <= maj;
  end
  assign par_bad = (^data_reg) ^ par_bit_reg;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state_reg <= RX_IDLE;
    else     rx_state_reg <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    case (rx_state_reg)
      RX_IDLE:  if (!need_idle_reg && !rx_s) rx_state_next = RX_START;
      RX_START: begin
        if (mid_tick && rx_s) rx_state_next = RX_IDLE;
        else if (bit_end)     rx_state_next = RX_DATA;
      end
      RX_DATA: begin
        if (bit_end && bit_cnt_reg == 3'd7) begin
`ifdef UART_PARITY_EN
          rx_state_next = RX_PAR;
`else
          rx_state_next = RX_STOP;
`endif
        end
      end
      RX_PAR:  if (bit_end) rx_state_next = RX_STOP;
      RX_STOP: if (mid_tick) rx_state_next = RX_IDLE;
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // Bit timing restarts at the detected start edge, so sample points sit mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg   <= '0;
      tick_cnt_reg  <= 4'd0;
      bit_cnt_reg   <= 3'd0;
      data_reg      <= 8'd0;
      vote0_reg     <= 1'b0;
      vote1_reg     <= 1'b0;
      need_idle_reg <= 1'b0;
      byte_vld_reg  <= 1'b0;
      rx_err_reg    <= 1'b0;
    end else begin
      byte_vld_reg <= 1'b0;
      rx_err_reg   <= 1'b0;
      if (rx_state_reg == RX_IDLE) begin
        div_cnt_reg  <= '0;
        tick_cnt_reg <= 4'd0;
        bit_cnt_reg  <= 3'd0;
        if (rx_s) need_idle_reg <= 1'b0;
      end else begin
        div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
        if (tick) begin
          tick_cnt_reg <= tick_cnt_reg + 4'd1;
          if (tick_cnt_reg == 4'd6) vote0_reg <= rx_s;
          if (tick_cnt_reg == 4'd7) vote1_reg <= rx_s;
          if (tick_cnt_reg == 4'd8 && rx_state_reg == RX_DATA) data_reg <= {maj, data_reg[7:1]};
          if (tick_cnt_reg == 4'd15 && rx_state_reg == RX_DATA) bit_cnt_reg <= bit_cnt_reg + 3'd1;
          if (tick_cnt_reg == 4'd7 && rx_state_reg == RX_STOP) begin
            byte_vld_reg  <= rx_s & ~par_bad;
            rx_err_reg    <= ~rx_s | par_bad;
            need_idle_reg <= ~rx_s;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_state_reg <= DEC_CMD;
      wave_reg      <= 3'b000;
      noise_reg     <= 1'b0;
      freq_reg      <= FREQ_RESET;
      shadow_reg    <= '0;
      has_digit_reg <= 1'b0;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      dec_state_reg <= dec_state_next;
      wave_reg      <= wave_next;
      noise_reg     <= noise_next;
      freq_reg      <= freq_next;
      shadow_reg    <= shadow_next;
      has_digit_reg <= has_digit_next;
      valid_reg     <= valid_next;
      err_reg       <= err_next;
    end
  end

  assign hex = hex_val(data_reg);

  always_comb begin
    dec_state_next = dec_state_reg;
    wave_next      = wave_reg;
    noise_next     = noise_reg;
    freq_next      = freq_reg;
    shadow_next    = shadow_reg;
    has_digit_next = has_digit_reg;
    valid_next     = 1'b0;
    err_next       = 1'b0;
    if (rx_err_reg) begin
      err_next       = 1'b1;
      dec_state_next = DEC_CMD;
    end else if (byte_vld_reg) begin
      if (dec_state_reg == DEC_HEX) begin
        // Shifting left naturally keeps only the most recent HEX_N digits.
        if (hex[4]) begin
          shadow_next    = (shadow_reg << 4) | FREQ_W'(hex[3:0]);
          has_digit_next = 1'b1;
        end else if (data_reg == 8'h0D && has_digit_reg) begin
          freq_next      = shadow_reg;
          valid_next     = 1'b1;
          dec_state_next = DEC_CMD;
        end else begin
          err_next       = 1'b1;
          dec_state_next = DEC_CMD;
        end
      end else begin
        case (data_reg)
          8'h54: begin wave_next  = 3'b000; valid_next = 1'b1; end
          8'h51: begin wave_next  = 3'b001; valid_next = 1'b1; end
          8'h57: begin wave_next  = 3'b010; valid_next = 1'b1; end
          8'h53: begin wave_next  = 3'b011; valid_next = 1'b1; end
          8'h4E: begin noise_next = 1'b1;   valid_next = 1'b1; end
          8'h46: begin noise_next = 1'b0;   valid_next = 1'b1; end
          8'h44: begin
            dec_state_next = DEC_HEX;
            shadow_next    = '0;
            has_digit_next = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign wave_sel  = wave_reg;
  assign noise_en  = noise_reg;
  assign freq_word = freq_reg;
  assign cmd_valid = valid_reg;
  assign cmd_err   = err_reg;

endmodule

// File: tb/tb_uart_wave_cmd_rx.sv
// Bench for uart_wave_cmd_rx: serialises command bytes, predicts each pulse with a decoder model
// and compares every pulse (kind, outputs, latency) against the queued prediction.
module tb_uart_wave_cmd_rx;
  localparam int DIV = 4;
  localparam int BIT = DIV * 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [2:0]  wave_sel;
  logic        noise_en;
  logic [15:0] freq_word;
  logic        cmd_valid;
  logic        cmd_err;

  uart_wave_cmd_rx #(
    .CLK_HZ(25_000_000), .BAUD(390_625), .FREQ_W(16), .FREQ_RESET(16'h0100)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .wave_sel(wave_sel), .noise_en(noise_en),
    .freq_word(freq_word), .cmd_valid(cmd_valid), .cmd_err(cmd_err)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_err;
    logic [2:0]  wave;
    logic        noise;
    logic [15:0] freq;
    int          due;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0]  m_wave;
  logic        m_noise;
  logic [15:0] m_freq;
  logic [15:0] m_shadow;
  logic        m_hex;
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    m_wave = 3'b000; m_noise = 1'b0; m_freq = 16'h0100; m_shadow = 16'h0; m_hex = 1'b0; m_cnt = 0;
  endtask

  task automatic push_exp(input logic is_err, input int due);
    exp_t e;
    e.is_err = is_err; e.wave = m_wave; e.noise = m_noise; e.freq = m_freq; e.due = due;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input logic frame_err, input int due);
    logic [3:0] nib;
    logic       is_hex;
    is_hex = 1'b1;
    nib    = 4'h0;
    if (b >= "0" && b <= "9")      nib = 4'(b - 8'd48);
    else if (b >= "A" && b <= "F") nib = 4'(b - 8'd55);
    else if (b >= "a" && b <= "f") nib = 4'(b - 8'd87);
    else is_hex = 1'b0;
    if (frame_err) begin
      m_hex = 1'b0;
      push_exp(1'b1, due);
    end else if (m_hex) begin
      if (is_hex) begin
        m_shadow = {m_shadow[11:0], nib};
        m_cnt++;
      end else begin
        m_hex = 1'b0;
        if (b == 8'h0D && m_cnt > 0) begin
          m_freq = m_shadow;
          push_exp(1'b0, due);
        end else begin
          push_exp(1'b1, due);
        end
      end
    end else begin
      case (b)
        "T": begin m_wave = 3'b000; push_exp(1'b0, due); end
        "Q": begin m_wave = 3'b001; push_exp(1'b0, due); end
        "W": begin m_wave = 3'b010; push_exp(1'b0, due); end
        "S": begin m_wave = 3'b011; push_exp(1'b0, due); end
        "N": begin m_noise = 1'b1;  push_exp(1'b0, due); end
        "F": begin m_noise = 1'b0;  push_exp(1'b0, due); end
        "D": begin m_hex = 1'b1; m_cnt = 0; m_shadow = 16'h0; end
        default: ;
      endcase
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_stop, input logic bad_par);
    rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(posedge clk);
    end
`ifdef UART_PARITY_EN
    rx = (^b) ^ bad_par;
    repeat (BIT) @(posedge clk);
`endif
    model_byte(b, bad_stop | bad_par, cyc + 8 * DIV);
    rx = ~bad_stop;
    repeat (BIT) @(posedge clk);
    rx = 1'b1;
    repeat (bad_stop ? BIT : 16) @(posedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(8'(s[i]), 1'b0, 1'b0);
  endtask

  task automatic check_model_outputs(input string tag);
    check_eq({tag, "_wave"},  32'(wave_sel),  32'(m_wave));
    check_eq({tag, "_noise"}, 32'(noise_en),  32'(m_noise));
    check_eq({tag, "_freq"},  32'(freq_word), 32'(m_freq));
  endtask

  // Scoreboard: every pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!rst && (cmd_valid || cmd_err)) begin
      check_eq("pulse_exclusive", 32'(cmd_valid & cmd_err), 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("spurious_pulse", {30'd0, cmd_valid, cmd_err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("txn: cycle %0d valid=%0b err=%0b wave=%0d noise=%0b freq=%04h",
                 cyc, cmd_valid, cmd_err, wave_sel, noise_en, freq_word);
        check_eq("pulse_kind_err", 32'(cmd_err), 32'(mon_e.is_err));
        check_eq("pulse_wave",     32'(wave_sel), 32'(mon_e.wave));
        check_eq("pulse_noise",    32'(noise_en), 32'(mon_e.noise));
        check_eq("pulse_freq",     32'(freq_word), 32'(mon_e.freq));
        check_eq("pulse_latency_window", 32'((cyc - mon_e.due) >= 2 && (cyc - mon_e.due) <= 8), 32'd1);
      end
    end
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_model_outputs("reset");
    check_eq("reset_valid", 32'(cmd_valid), 32'd0);
    check_eq("reset_err",   32'(cmd_err),   32'd0);
    @(posedge clk);
    rst = 1'b0;
    repeat (2 * BIT) @(posedge clk);

    send_str("Q");
    send_str("NF");
    send_str("D1aF3\r");
    send_str("D12345\r");
    send_str("DG");
    send_str("T");
    send_str("\n");
    send_frame(8'h51, 1'b1, 1'b0);
    @(negedge clk);
    check_model_outputs("after_bad_stop");

    // Short low glitch on an idle line must not start a byte.
    @(posedge clk);
    rx = 1'b0;
    repeat (5 * DIV) @(posedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    @(negedge clk);
    check_model_outputs("after_glitch");

    // Reset in the middle of hex entry and mid-frame.
    send_str("D1");
    @(posedge clk);
    rx = 1'b0;
    repeat (4 * BIT) @(posedge clk);
    rx  = 1'b1;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_model_outputs("midreset");
    check_eq("midreset_valid", 32'(cmd_valid), 32'd0);
    check_eq("midreset_err",   32'(cmd_err),   32'd0);
    check_eq("midreset_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    rst = 1'b0;
    repeat (2 * BIT) @(posedge clk);
    send_str("W");

`ifdef UART_PARITY_EN
    send_frame(8'h53, 1'b0, 1'b1);
    send_frame(8'h53, 1'b0, 1'b0);
`endif

    repeat (2 * BIT) @(posedge clk);
    @(negedge clk);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    check_model_outputs("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
